// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Brief    : Shared pipeline control types and default widths.
//  Revision : 1.0
// ============================================================================
package pipe_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 6;

    typedef struct packed {
        logic               pcsrc;
        logic               alusrc;
        logic               memtoreg;
        logic               we;
        logic               reg_en;
        logic               br;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

    // Side-effecting controls must not leak out of an invalid ID slot.
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
        ctrl_t g;
        g          = c;
        g.pcsrc    = c.pcsrc    & valid;
        g.memtoreg = c.memtoreg & valid;
        g.we       = c.we       & valid;
        g.reg_en   = c.reg_en   & valid;
        g.br       = c.br       & valid;
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module   : load_use_detect
//  Brief    : Combinational load-use comparator between EX and ID.
//  Revision : 1.0
// ============================================================================
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid_i,
    input  logic              ex_memtoreg_i,
    input  logic              ex_reg_en_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic              rs1_used_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              rs2_used_i,
    output logic              load_use_o
);

    logic ex_is_load;
    logic src_match;

    // x0 is hardwired, so a load targeting it never produces a dependency.
    assign ex_is_load = ex_valid_i & ex_memtoreg_i & ex_reg_en_i & (ex_rd_i != '0);
    assign src_match  = (rs1_used_i & (rs1_i == ex_rd_i)) |
                        (rs2_used_i & (rs2_i == ex_rd_i));
    assign load_use_o = ex_is_load & id_valid_i & src_match;

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe
//  Brief    : ID/EX pipeline register with stall, flush, load-use bubble.
//  Revision : 1.0
// ============================================================================
module id_ex_pipe #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [XLEN-1:0]    data_in_1,
    input  logic [XLEN-1:0]    data_in_2,
    input  logic [REG_AW-1:0]  rs1_in,
    input  logic [REG_AW-1:0]  rs2_in,
    input  logic               rs1_used_in,
    input  logic               rs2_used_in,
    input  logic [REG_AW-1:0]  rd_in,
    input  logic [XLEN-1:0]    imm_in,
    input  logic [XLEN-1:0]    pipe_pc_in,
    input  logic               pcsrc_in,
    input  logic               alusrc_in,
    input  logic               memtoreg_in,
    input  logic               we_in,
    input  logic               reg_en_in,
    input  logic               br_in,
    input  logic [ALUOP_W-1:0] aluop_in,
    input  logic               stall_in,
    input  logic               flush_in,
    output logic               valid_out,
    output logic [XLEN-1:0]    data_out_1,
    output logic [XLEN-1:0]    data_out_2,
    output logic [XLEN-1:0]    imm_out,
    output logic [XLEN-1:0]    pipe_pc_out,
    output logic [REG_AW-1:0]  rs1_out,
    output logic [REG_AW-1:0]  rs2_out,
    output logic [REG_AW-1:0]  rd_out,
    output logic               pcsrc_out,
    output logic               alusrc_out,
    output logic               memtoreg_out,
    output logic               we_out,
    output logic               reg_en_out,
    output logic               br_out,
    output logic [ALUOP_W-1:0] aluop_out,
    output logic               hazard_stall,
    output logic [CNT_W-1:0]   bubble_count
);
    import pipe_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   data1_q, data1_d, data2_q, data2_d;
    logic [XLEN-1:0]   imm_q, imm_d, pc_q, pc_d;
    logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    ctrl_t ctrl_in;
    logic  load_use;
    logic  take_bubble;

    assign ctrl_in = {pcsrc_in, alusrc_in, memtoreg_in, we_in, reg_en_in, br_in, aluop_in};

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_valid_i    (valid_q),
        .ex_memtoreg_i (ctrl_q.memtoreg),
        .ex_reg_en_i   (ctrl_q.reg_en),
        .ex_rd_i       (rd_q),
        .id_valid_i    (valid_in),
        .rs1_i         (rs1_in),
        .rs1_used_i    (rs1_used_in),
        .rs2_i         (rs2_in),
        .rs2_used_i    (rs2_used_in),
        .load_use_o    (load_use)
    );

    // A flush kills the EX occupant, so there is nothing left to wait for.
    assign hazard_stall = load_use & ~flush_in;
    assign take_bubble  = flush_in | (~stall_in & load_use);

    always_comb begin
        valid_d = valid_q;
        data1_d = data1_q;
        data2_d = data2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;

        if (take_bubble) begin
            valid_d = 1'b0;
            data1_d = '0;
            data2_d = '0;
            imm_d   = '0;
            pc_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            ctrl_d  = BUBBLE_CTRL;
        end else if (!stall_in) begin
            valid_d = valid_in;
            data1_d = data_in_1;
            data2_d = data_in_2;
            imm_d   = imm_in;
            pc_d    = pipe_pc_in;
            rs1_d   = rs1_in;
            rs2_d   = rs2_in;
            rd_d    = rd_in;
            ctrl_d  = gate_ctrl(ctrl_in, valid_in);
        end

        // Only hazard bubbles count; flush and stall cycles are not performance loss here.
        if (!flush_in && !stall_in && load_use && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= BUBBLE_CTRL;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_out    = valid_q;
    assign data_out_1   = data1_q;
    assign data_out_2   = data2_q;
    assign imm_out      = imm_q;
    assign pipe_pc_out  = pc_q;
    assign rs1_out      = rs1_q;
    assign rs2_out      = rs2_q;
    assign rd_out       = rd_q;
    assign pcsrc_out    = ctrl_q.pcsrc;
    assign alusrc_out   = ctrl_q.alusrc;
    assign memtoreg_out = ctrl_q.memtoreg;
    assign we_out       = ctrl_q.we;
    assign reg_en_out   = ctrl_q.reg_en;
    assign br_out       = ctrl_q.br;
    assign aluop_out    = ctrl_q.aluop;
    assign bubble_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_pipe
//  Brief    : Self-checking bench for id_ex_pipe against a behavioural model.
//  Revision : 1.0
// ============================================================================
module tb_id_ex_pipe;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 6;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    d1;
        logic [XLEN-1:0]    d2;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic               rs1u;
        logic               rs2u;
        logic [REG_AW-1:0]  rd;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        logic               pcsrc;
        logic               alusrc;
        logic               memtoreg;
        logic               we;
        logic               reg_en;
        logic               br;
        logic [ALUOP_W-1:0] aluop;
        logic               stall;
        logic               flush;
    } in_t;

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    d1;
        logic [XLEN-1:0]    d2;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic               pcsrc;
        logic               alusrc;
        logic               memtoreg;
        logic               we;
        logic               reg_en;
        logic               br;
        logic [ALUOP_W-1:0] aluop;
    } ex_t;

    logic               clock, reset;
    logic               valid_in, rs1_used_in, rs2_used_in;
    logic [XLEN-1:0]    data_in_1, data_in_2, imm_in, pipe_pc_in;
    logic [REG_AW-1:0]  rs1_in, rs2_in, rd_in;
    logic               pcsrc_in, alusrc_in, memtoreg_in, we_in, reg_en_in, br_in;
    logic [ALUOP_W-1:0] aluop_in;
    logic               stall_in, flush_in;
    logic               valid_out;
    logic [XLEN-1:0]    data_out_1, data_out_2, imm_out, pipe_pc_out;
    logic [REG_AW-1:0]  rs1_out, rs2_out, rd_out;
    logic               pcsrc_out, alusrc_out, memtoreg_out, we_out, reg_en_out, br_out;
    logic [ALUOP_W-1:0] aluop_out;
    logic               hazard_stall;
    logic [CNT_W-1:0]   bubble_count;

    id_ex_pipe #(
        .XLEN(XLEN), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in),
        .data_in_1(data_in_1), .data_in_2(data_in_2),
        .rs1_in(rs1_in), .rs2_in(rs2_in),
        .rs1_used_in(rs1_used_in), .rs2_used_in(rs2_used_in),
        .rd_in(rd_in), .imm_in(imm_in), .pipe_pc_in(pipe_pc_in),
        .pcsrc_in(pcsrc_in), .alusrc_in(alusrc_in), .memtoreg_in(memtoreg_in),
        .we_in(we_in), .reg_en_in(reg_en_in), .br_in(br_in), .aluop_in(aluop_in),
        .stall_in(stall_in), .flush_in(flush_in),
        .valid_out(valid_out), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .imm_out(imm_out), .pipe_pc_out(pipe_pc_out),
        .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
        .pcsrc_out(pcsrc_out), .alusrc_out(alusrc_out), .memtoreg_out(memtoreg_out),
        .we_out(we_out), .reg_en_out(reg_en_out), .br_out(br_out), .aluop_out(aluop_out),
        .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int  tests_run = 0;
    int  fails     = 0;
    ex_t m_ex;
    int  m_cnt;

    // Reference: what EX should hold and how many hazard bubbles have occurred.
    function automatic bit m_load_use(input in_t s);
        bit hit;
        hit = (s.rs1u && s.rs1 == m_ex.rd) || (s.rs2u && s.rs2 == m_ex.rd);
        return m_ex.valid && m_ex.memtoreg && m_ex.reg_en && (m_ex.rd != 0) && s.valid && hit;
    endfunction

    function automatic ex_t capture(input in_t s);
        ex_t e;
        e.valid    = s.valid;
        e.d1       = s.d1;
        e.d2       = s.d2;
        e.imm      = s.imm;
        e.pc       = s.pc;
        e.rs1      = s.rs1;
        e.rs2      = s.rs2;
        e.rd       = s.rd;
        e.alusrc   = s.alusrc;
        e.aluop    = s.aluop;
        e.pcsrc    = s.valid ? s.pcsrc    : 1'b0;
        e.memtoreg = s.valid ? s.memtoreg : 1'b0;
        e.we       = s.valid ? s.we       : 1'b0;
        e.reg_en   = s.valid ? s.reg_en   : 1'b0;
        e.br       = s.valid ? s.br       : 1'b0;
        return e;
    endfunction

    function automatic ex_t dut_ex();
        return {valid_out, data_out_1, data_out_2, imm_out, pipe_pc_out,
                rs1_out, rs2_out, rd_out, pcsrc_out, alusrc_out, memtoreg_out,
                we_out, reg_en_out, br_out, aluop_out};
    endfunction

    function automatic in_t rand_in();
        in_t s;
        s.valid    = ($urandom_range(0, 3) != 0);
        s.d1       = $urandom;
        s.d2       = $urandom;
        s.rs1      = REG_AW'($urandom_range(0, 3));
        s.rs2      = REG_AW'($urandom_range(0, 3));
        s.rs1u     = 1'($urandom_range(0, 1));
        s.rs2u     = 1'($urandom_range(0, 1));
        s.rd       = REG_AW'($urandom_range(0, 3));
        s.imm      = $urandom;
        s.pc       = $urandom;
        s.pcsrc    = 1'($urandom_range(0, 1));
        s.alusrc   = 1'($urandom_range(0, 1));
        s.memtoreg = 1'($urandom_range(0, 1));
        s.we       = 1'($urandom_range(0, 1));
        s.reg_en   = 1'($urandom_range(0, 1));
        s.br       = 1'($urandom_range(0, 1));
        s.aluop    = ALUOP_W'($urandom);
        s.stall    = ($urandom_range(0, 4) == 0);
        s.flush    = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    task automatic drive(input in_t s);
        valid_in    = s.valid;    data_in_1   = s.d1;       data_in_2 = s.d2;
        rs1_in      = s.rs1;      rs2_in      = s.rs2;
        rs1_used_in = s.rs1u;     rs2_used_in = s.rs2u;     rd_in     = s.rd;
        imm_in      = s.imm;      pipe_pc_in  = s.pc;
        pcsrc_in    = s.pcsrc;    alusrc_in   = s.alusrc;   memtoreg_in = s.memtoreg;
        we_in       = s.we;       reg_en_in   = s.reg_en;   br_in       = s.br;
        aluop_in    = s.aluop;    stall_in    = s.stall;    flush_in    = s.flush;
    endtask

    task automatic apply(input in_t s);
        @(negedge clock);
        drive(s);
        #1;
    endtask

    task automatic clock_in(input in_t s);
        bit lu;
        lu = m_load_use(s);
        @(posedge clock);
        if (s.flush) begin
            m_ex = '0;
        end else if (s.stall) begin
            m_ex = m_ex;
        end else if (lu) begin
            m_ex = '0;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_ex = capture(s);
        end
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        drive('0);
        @(negedge clock);
        reset = 1'b0;
        m_ex  = '0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        in_t s;
        s = '1; s.stall = 0; s.flush = 0; s.rs1u = 0; s.rs2u = 0;
        apply(s); clock_in(s);
        s.rs1u = 1;
        apply(s);
        tests_run++;
        if (hazard_stall !== 1'b1) begin
            fails++; $display("FAIL reset_prehazard: hazard_stall=%0b expected 1", hazard_stall);
        end
        clock_in(s);
        tests_run++;
        if (bubble_count !== CNT_W'(1)) begin
            fails++; $display("FAIL reset_precount: bubble_count=%0d expected 1", bubble_count);
        end
        s.rs1u = 0; apply(s); clock_in(s);
        s.rs1u = 1; apply(s);
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (dut_ex() !== ex_t'('0)) begin
            fails++; $display("FAIL reset_async_outputs: got %h expected 0", dut_ex());
        end
        tests_run++;
        if (bubble_count !== '0 || hazard_stall !== 1'b0) begin
            fails++; $display("FAIL reset_async_cnt_hz: count=%0d hz=%0b expected 0/0", bubble_count, hazard_stall);
        end
        @(posedge clock); #1;
        tests_run++;
        if (dut_ex() !== ex_t'('0) || bubble_count !== '0) begin
            fails++; $display("FAIL reset_held: got %h cnt %0d expected 0", dut_ex(), bubble_count);
        end
        @(negedge clock);
        reset = 1'b0;
        drive('0);
        m_ex = '0; m_cnt = 0;
    endtask

    task automatic test_normal_flow();
        in_t s;
        s = '0; s.valid = 1; s.d1 = 32'h11; s.imm = 32'h7FF; s.rd = 5; s.we = 1; s.reg_en = 1; s.pc = 32'h100;
        apply(s); clock_in(s);
        tests_run++;
        if (valid_out !== 1'b1 || data_out_1 !== 32'h11 || imm_out !== 32'h7FF ||
            rd_out !== 5'd5 || we_out !== 1'b1 || pipe_pc_out !== 32'h100) begin
            fails++; $display("FAIL normal_fields: got %h expected valid,d1=11,imm=7ff,rd=5,we,pc=100", dut_ex());
        end
        tests_run++;
        if (dut_ex() !== m_ex) begin
            fails++; $display("FAIL normal_model: got %h expected %h", dut_ex(), m_ex);
        end
        s.valid = 0;
        apply(s); clock_in(s);
        tests_run++;
        if (we_out !== 1'b0 || reg_en_out !== 1'b0 || valid_out !== 1'b0 || data_out_1 !== 32'h11) begin
            fails++; $display("FAIL normal_invalid_gating: got %h expected gated controls", dut_ex());
        end
    endtask

    task automatic test_load_use();
        in_t ld, id;
        ld = '0; ld.valid = 1; ld.memtoreg = 1; ld.reg_en = 1; ld.rd = 7; ld.pc = 32'h300;
        apply(ld); clock_in(ld);
        id = '0; id.valid = 1; id.rs2u = 1; id.rs2 = 7; id.rd = 3; id.pc = 32'h304;
        apply(id);
        tests_run++;
        if (hazard_stall !== 1'b1) begin
            fails++; $display("FAIL loaduse_detect: hazard_stall=%0b expected 1", hazard_stall);
        end
        clock_in(id);
        tests_run++;
        if (valid_out !== 1'b0 || bubble_count !== CNT_W'(1) || dut_ex() !== ex_t'('0)) begin
            fails++; $display("FAIL loaduse_bubble: got %h cnt=%0d expected 0 cnt=1", dut_ex(), bubble_count);
        end
        apply(id);
        tests_run++;
        if (hazard_stall !== 1'b0) begin
            fails++; $display("FAIL loaduse_recover_hz: hazard_stall=%0b expected 0", hazard_stall);
        end
        clock_in(id);
        tests_run++;
        if (dut_ex() !== m_ex || valid_out !== 1'b1 || rd_out !== 5'd3) begin
            fails++; $display("FAIL loaduse_recover_load: got %h expected %h", dut_ex(), m_ex);
        end
        ld.rd = 0;
        apply(ld); clock_in(ld);
        id = '0; id.valid = 1; id.rs1u = 1; id.rs2u = 1;
        apply(id);
        tests_run++;
        if (hazard_stall !== 1'b0) begin
            fails++; $display("FAIL loaduse_rd0: hazard_stall=%0b expected 0", hazard_stall);
        end
        clock_in(id);
        ld.rd = 7;
        apply(ld); clock_in(ld);
        id = '0; id.valid = 1; id.rs2 = 7; id.rs1u = 1; id.rs1 = 4;
        apply(id);
        tests_run++;
        if (hazard_stall !== 1'b0) begin
            fails++; $display("FAIL loaduse_rs2_unused: hazard_stall=%0b expected 0", hazard_stall);
        end
        clock_in(id);
        tests_run++;
        if (dut_ex() !== m_ex || bubble_count !== CNT_W'(m_cnt)) begin
            fails++; $display("FAIL loaduse_nohz_load: got %h cnt %0d expected %h cnt %0d", dut_ex(), bubble_count, m_ex, m_cnt);
        end
    endtask

    task automatic test_stall();
        in_t s;
        int  cnt0;
        s = '0; s.valid = 1; s.memtoreg = 1; s.reg_en = 1; s.rd = 9; s.pc = 32'h200;
        apply(s); clock_in(s);
        cnt0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            s = rand_in(); s.stall = 1; s.flush = 0; s.valid = 1; s.rs1u = 1; s.rs1 = 9;
            apply(s);
            tests_run++;
            if (hazard_stall !== 1'b1) begin
                fails++; $display("FAIL stall_hz[%0d]: hazard_stall=%0b expected 1", i, hazard_stall);
            end
            clock_in(s);
            tests_run++;
            if (pipe_pc_out !== 32'h200 || bubble_count !== CNT_W'(cnt0) || dut_ex() !== m_ex) begin
                fails++; $display("FAIL stall_hold[%0d]: pc=%h cnt=%0d expected pc=200 cnt=%0d", i, pipe_pc_out, bubble_count, cnt0);
            end
        end
    endtask

    task automatic test_flush_over_stall();
        in_t s;
        int  cnt0;
        cnt0 = m_cnt;
        s = '0; s.stall = 1; s.flush = 1; s.valid = 1; s.rs1u = 1; s.rs1 = 9; s.pc = 32'h444;
        apply(s);
        tests_run++;
        if (hazard_stall !== 1'b0) begin
            fails++; $display("FAIL flush_hz: hazard_stall=%0b expected 0", hazard_stall);
        end
        clock_in(s);
        tests_run++;
        if (dut_ex() !== ex_t'('0) || bubble_count !== CNT_W'(cnt0)) begin
            fails++; $display("FAIL flush_bubble: got %h cnt=%0d expected 0 cnt=%0d", dut_ex(), bubble_count, cnt0);
        end
    endtask

    task automatic test_saturation();
        in_t ld, id;
        pulse_reset();
        ld = '0; ld.valid = 1; ld.memtoreg = 1; ld.reg_en = 1; ld.rd = 12;
        id = '0; id.valid = 1; id.rs1u = 1; id.rs1 = 12;
        for (int i = 0; i < 5; i++) begin
            apply(ld); clock_in(ld);
            apply(id); clock_in(id);
            tests_run++;
            if (bubble_count !== CNT_W'((i + 1 > CNT_MAX) ? CNT_MAX : i + 1)) begin
                fails++; $display("FAIL sat_count[%0d]: bubble_count=%0d expected %0d", i, bubble_count,
                                  (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
            end
        end
    endtask

    task automatic test_random();
        in_t s;
        bit  exp_hz;
        int  bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            s = rand_in();
            apply(s);
            exp_hz = m_load_use(s) && !s.flush;
            tests_run++;
            if (hazard_stall !== exp_hz) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL rand_hz[%0d]: hazard_stall=%0b expected %0b", i, hazard_stall, exp_hz);
            end
            clock_in(s);
            tests_run++;
            if (dut_ex() !== m_ex || bubble_count !== CNT_W'(m_cnt)) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL rand_state[%0d]: got %h cnt %0d expected %h cnt %0d",
                                       i, dut_ex(), bubble_count, m_ex, m_cnt);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive('0);
        m_ex  = '0;
        m_cnt = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_normal_flow();
        test_load_use();
        test_stall();
        test_flush_over_stall();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
